// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// mm_pkg : shared FSM type, default widths and index helper for the matmul
//          MAC sequencer.                                         Rev 1.0
// ============================================================================
package mm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } mm_state_e;

  localparam int MM_N_DEF     = 3;
  localparam int MM_AW_DEF    = 9;
  localparam int MM_BW_DEF    = 8;
  localparam int MM_ACC_W_DEF = 19;

  // Row-major element index of (row, col) in an n x n matrix.
  function automatic int mm_idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mm_mac_unit.sv
`default_nettype none
// ============================================================================
// mm_mac_unit : shared multiplier, accumulate adder with carry-out and the
//               accumulator register.                             Rev 1.0
// ============================================================================
module mm_mac_unit #(
  parameter int AW    = 9,
  parameter int BW    = 8,
  parameter int ACC_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic             accum,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [AW+BW-1:0] prod;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;

  mm_umul #(.AW(AW), .BW(BW)) u_mul (
    .a (a),
    .b (b),
    .p (prod)
  );

  // One extra bit on the adder exposes the wrap as carry.
  assign sum   = {1'b0, acc_q} + (ACC_W + 1)'(prod);
  assign carry = sum[ACC_W];
  assign acc   = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (load) begin
      acc_d = ACC_W'(prod);
    end else if (accum) begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mm_umul.sv
`default_nettype none
// ============================================================================
// mm_umul : full-width unsigned multiplier wrapper.               Rev 1.0
// ============================================================================
module mm_umul #(
  parameter int AW = 9,
  parameter int BW = 8
) (
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic [AW+BW-1:0] p
);

  assign p = (AW + BW)'(a) * (AW + BW)'(b);

endmodule
`default_nettype wire

// File: rtl/matmul_mac_sequencer.sv
`default_nettype none
// ============================================================================
// matmul_mac_sequencer : computes C = A x B one MAC term per cycle and emits
//                        each C element over a valid/ready port.   Rev 1.0
// ============================================================================
module matmul_mac_sequencer
  import mm_pkg::*;
#(
  parameter int  N      = MM_N_DEF,
  parameter int  AW     = MM_AW_DEF,
  parameter int  BW     = MM_BW_DEF,
  parameter int  ACC_W  = MM_ACC_W_DEF,
  localparam int ADDR_W = $clog2(N * N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [AW-1:0]     a_data,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [BW-1:0]     b_data,
  output logic              c_valid,
  input  logic              c_ready,
  output logic [ADDR_W-1:0] c_addr,
  output logic [ACC_W-1:0]  c_data
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  mm_state_e         state_q, state_d;
  logic [CW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
  logic              ovf_q, ovf_d;
  logic              busy_q, busy_d, done_q, done_d, c_valid_q, c_valid_d;
  logic [ADDR_W-1:0] a_last_q, a_last_d, b_last_q, b_last_d;
  logic [ADDR_W-1:0] a_idx, b_idx, c_idx;
  logic              mac_clr, mac_load, mac_accum, mac_carry;
  logic [ACC_W-1:0]  acc;

  assign a_idx = ADDR_W'(mm_idx(int'(i_q), int'(k_q), N));
  assign b_idx = ADDR_W'(mm_idx(int'(k_q), int'(j_q), N));
  assign c_idx = ADDR_W'(mm_idx(int'(i_q), int'(j_q), N));

  mm_mac_unit #(.AW(AW), .BW(BW), .ACC_W(ACC_W)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .load  (mac_load),
    .accum (mac_accum),
    .a     (a_data),
    .b     (b_data),
    .acc   (acc),
    .carry (mac_carry)
  );

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    ovf_d     = ovf_q;
    a_last_d  = a_last_q;
    b_last_d  = b_last_q;
    mac_clr   = 1'b0;
    mac_load  = 1'b0;
    mac_accum = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          ovf_d   = 1'b0;
          mac_clr = 1'b1;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        a_last_d = a_idx;
        b_last_d = b_idx;
        if (k_q == '0) begin
          mac_load = 1'b1;
        end else begin
          mac_accum = 1'b1;
          ovf_d     = ovf_q | mac_carry;
        end
        if (k_q == C_LAST) begin
          state_d = ST_OUT;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      ST_OUT: begin
        if (c_ready) begin
          k_d     = '0;
          state_d = ST_MAC;
          if (j_q == C_LAST) begin
            j_d = '0;
            if (i_q == C_LAST) begin
              i_d     = '0;
              state_d = ST_DONE;
            end else begin
              i_d = i_q + CW'(1);
            end
          end else begin
            j_d = j_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d    = (state_d == ST_MAC) || (state_d == ST_OUT);
    done_d    = (state_d == ST_DONE);
    c_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      k_q       <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      c_valid_q <= 1'b0;
      a_last_q  <= '0;
      b_last_q  <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      k_q       <= k_d;
      ovf_q     <= ovf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      c_valid_q <= c_valid_d;
      a_last_q  <= a_last_d;
      b_last_q  <= b_last_d;
    end
  end

  // Read addresses are live only in MAC and otherwise hold the last term.
  assign a_addr  = (state_q == ST_MAC) ? a_idx : a_last_q;
  assign b_addr  = (state_q == ST_MAC) ? b_idx : b_last_q;
  assign c_addr  = c_idx;
  assign c_data  = acc;
  assign c_valid = c_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_mac_sequencer.sv
`default_nettype none
// ============================================================================
// tb_matmul_mac_sequencer : scoreboard bench for the matmul MAC sequencer.
//                                                                 Rev 1.0
// ============================================================================
module tb_matmul_mac_sequencer;

  localparam int N     = 3;
  localparam int AW    = 9;
  localparam int BW    = 8;
  localparam int ACC_W = 17;
  localparam int AD    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, ovf, c_valid;
  logic              c_ready;
  logic [AD-1:0]     a_addr, b_addr, c_addr;
  logic [AW-1:0]     a_data;
  logic [BW-1:0]     b_data;
  logic [ACC_W-1:0]  c_data;

  logic [AW-1:0] a_mem [16];
  logic [BW-1:0] b_mem [16];

  assign a_data = a_mem[a_addr];
  assign b_data = b_mem[b_addr];

  matmul_mac_sequencer #(.N(N), .AW(AW), .BW(BW), .ACC_W(ACC_W)) dut (
    .clk     (clk),
    .reset   (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .c_addr  (c_addr),
    .c_data  (c_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     addr;
    longint data;
    bit     ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   beats = 0;
  int   stalls = 0;
  int   dones = 0;
  bit   rand_ready = 1'b0;
  bit   job_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    c_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      c_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pops, stall stability, beat/stall/done counts.
  initial begin
    bit            prev_stall = 1'b0;
    logic [AD-1:0] prev_addr;
    logic [ACC_W-1:0] prev_data;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", c_valid, 1);
          check("stall_addr_stable", c_addr, prev_addr);
          check("stall_data_stable", c_data, prev_data);
        end
        if (done) dones++;
        if (c_valid && c_ready) begin
          beats++;
          if (sb.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            e = sb.pop_front();
            check("c_addr", c_addr, e.addr);
            check("c_data", c_data, e.data);
            check("ovf_at_beat", ovf, e.ovf);
          end
        end
        if (c_valid && !c_ready) stalls++;
        prev_stall = c_valid && !c_ready;
        prev_addr  = c_addr;
        prev_data  = c_data;
      end
    end
  end

  task automatic load_mats(input int sel);
    for (int x = 0; x < 16; x++) begin
      a_mem[x] = '0;
      b_mem[x] = '0;
    end
    for (int x = 0; x < N * N; x++) begin
      if (sel == 2) begin
        a_mem[x] = 9'd511;
        b_mem[x] = 8'd255;
      end else begin
        a_mem[x] = AW'(x + 1);
        if (sel == 0) b_mem[x] = ((x / N) == (x % N)) ? 8'd1 : 8'd0;
        else          b_mem[x] = BW'(9 - x);
      end
    end
  endtask

  task automatic push_expected();
    bit     sticky = 1'b0;
    longint acc;
    longint lim = longint'(1) << ACC_W;
    exp_t   e;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          acc = acc + longint'(a_mem[i*N+k]) * longint'(b_mem[k*N+j]);
          if (acc >= lim) begin
            sticky = 1'b1;
            acc    = acc - lim;
          end
        end
        e.addr = i * N + j;
        e.data = acc;
        e.ovf  = sticky;
        sb.push_back(e);
      end
    end
    job_ovf = sticky;
  endtask

  task automatic run_job(input string tag, input bit rnd, input bit spurious);
    int start_cyc;
    int d0;
    int t;
    push_expected();
    rand_ready = rnd;
    @(negedge clk);
    beats  = 0;
    stalls = 0;
    d0     = dones;
    start  = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    start_cyc = cyc;
    check({tag, "_busy_after_start"}, busy, 1);
    check({tag, "_ovf_cleared"}, ovf, 0);
    t = 0;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
      if (spurious) start = ((cyc - start_cyc) == 4) || ((cyc - start_cyc) == 19);
    end
    start = 1'b0;
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, cyc - start_cyc + 1, 37 + stalls);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_beats"}, beats, 9);
    check({tag, "_sb_empty"}, sb.size(), 0);
    check({tag, "_ovf_at_done"}, ovf, job_ovf);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_single_done"}, dones - d0, 1);
    check({tag, "_ovf_held"}, ovf, job_ovf);
    rand_ready = 1'b0;
  endtask

  initial begin
    int t;
    int d0;
    int seen;
    load_mats(0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, ovf, c_valid, a_addr, b_addr, c_addr, c_data}, 0);
    rst = 1'b0;
    @(negedge clk);

    load_mats(0); run_job("identity", 1'b0, 1'b0);
    load_mats(1); run_job("general", 1'b0, 1'b0);
    load_mats(2); run_job("overflow", 1'b0, 1'b0);
    load_mats(1); run_job("after_ovf", 1'b0, 1'b0);
    load_mats(1); run_job("backpressure", 1'b1, 1'b0);
    check("backpressure_stalled", stalls > 0, 1);
    load_mats(1); run_job("start_busy", 1'b0, 1'b1);

    // Abort a job while element 4 is being presented.
    load_mats(1);
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(c_valid && c_addr == AD'(4)) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reset_reached_elem4", c_valid && c_addr == AD'(4), 1);
    #1 rst = 1'b1;
    #1;
    check("midjob_reset_outputs", {busy, done, ovf, c_valid, a_addr, b_addr, c_addr, c_data}, 0);
    sb.delete();
    @(negedge clk);
    rst  = 1'b0;
    d0   = dones;
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (c_valid) seen++;
    end
    check("no_done_after_reset", dones - d0, 0);
    check("no_valid_after_reset", seen, 0);
    run_job("fresh", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/matmul_mac_sequencer.md
Name: matmul_mac_sequencer

Overview:
- Sequences one shared unsigned multiplier and one accumulating adder to compute C = A x B for square N x N matrices.
- A and B live in external combinational-read storage addressed by this block. Each C element is emitted through a valid/ready output port.
- Sits between the operand storage and the result sink in the MatrixMult datapath. It is the only owner of the multiply/add resource.

Parameters:
- N, 3, matrix dimension (N >= 2).
- AW, 9, A element width (unsigned).
- BW, 8, B element width (unsigned).
- ACC_W, 19, accumulator / C element width; must be >= AW+BW.
- ADDR_W (localparam), clog2(N*N), row-major element index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle job request; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at job end.
- ovf  out  1  sticky: any accumulation in the current job exceeded ACC_W bits.
- a_addr  out  ADDR_W  A index, i*N+k.
- a_data  in  AW  A element, valid in the same cycle as a_addr.
- b_addr  out  ADDR_W  B index, k*N+j.
- b_data  in  BW  B element, valid in the same cycle as b_addr.
- c_valid  out  1  C element available.
- c_ready  in  1  sink accepts C element.
- c_addr  out  ADDR_W  C index, i*N+j.
- c_data  out  ACC_W  C element value.

Behaviour:
- Reset (async, any time): state=IDLE; i=j=k=0; acc=0. Outputs busy, done, ovf, c_valid, a_addr, b_addr, c_addr, c_data all 0.
- A reset mid-job abandons the job silently. No done pulse, no c_valid afterwards.
- FSM states: IDLE, MAC, OUT, DONE.
- IDLE
  - On start=1: clear i, j, k, acc and ovf; go to MAC.
  - start in any other state is ignored and is not queued.
- MAC (one term per cycle)
  - Drive a_addr = i*N+k and b_addr = k*N+j.
  - prod = a_data*b_data, full width AW+BW.
  - k==0: acc <= prod.
  - k>0: acc <= (acc+prod) mod 2^ACC_W. Set ovf if the true sum >= 2^ACC_W.
  - If k==N-1: go to OUT, else k++.
- OUT
  - c_valid=1, c_data=acc, c_addr=i*N+j, all held stable until c_ready=1.
  - On the c_valid&c_ready cycle, k<=0 and indices advance row-major: j++; when j wraps at N, j=0 and i++.
  - If (i,j) was (N-1,N-1): go to DONE, else go to MAC.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, then IDLE.
- a_addr/b_addr hold their last value outside MAC. Storage reads are assumed side-effect free.
- Latency with c_ready held high: done is asserted in cycle N*N*(N+1)+1 after the start-sampling edge (37 for N=3).
  - Each cycle of c_ready=0 in OUT adds one cycle.
- ovf remains valid after done until the next accepted start.
- c_data is not modified while c_valid=1 and c_ready=0.

Decomposition:
- Shared package mm_pkg holds:
  - FSM state enum (IDLE/MAC/OUT/DONE);
  - default width constants (AW=9, BW=8, ACC_W=19);
  - an index-to-address helper function.
- One natural sub-module, mm_mac_unit, containing:
  - the multiplier (instance of the team's unsigned multiplier wrapper);
  - the accumulate adder with carry-out;
  - the acc register.
  - Interface: load/accumulate enable, operands, acc, carry.
- The sequencer contains the FSM, counters, handshake and ovf logic only.

Test Plan:
- Identity B: N=3, A=[[1,2,3],[4,5,6],[7,8,9]], B=I, c_ready=1, start pulse -> C emitted in order 0..8 equals A; done at cycle 37; ovf=0; exactly 9 c_valid&c_ready beats.
- General product: A as above, B=[[9,8,7],[6,5,4],[3,2,1]] -> C=[[30,24,18],[84,69,54],[138,114,90]]; ovf=0.
- Overflow: ACC_W=17, A all 511, B all 255 -> every C element 128771 (390915 mod 131072); ovf=1 after the first element and held through done; next start clears ovf.
- Backpressure: random c_ready with 50% duty -> c_data and c_addr stable while stalled; same C values as the general-product test; done delayed by exactly the number of stall cycles.
- start while busy: pulse start at cycles 5 and 20 -> no effect on sequence or outputs; single done.
- Reset mid-job: assert reset during the OUT of element 4 -> all outputs 0 immediately; no done; a fresh start yields the complete correct C from element 0.
